// File: rtl/key_device_pkg.sv
// key_device_pkg: shared constants for the memory-mapped key (push-button) device.
//   Register offsets, KCTRL bit positions, default base addresses and a helper
//   that packs the KCTRL status word.
package key_device_pkg;

  localparam int unsigned BUS_BITS = 32;

  // Peripheral base addresses on the shared memAddr bus
  localparam logic [BUS_BITS-1:0] LED_BASE = 32'hF000_0000;
  localparam logic [BUS_BITS-1:0] KEY_BASE = 32'hF000_0010;

  // Register offsets relative to the key device base
  localparam int unsigned KDATA_OFFSET = 0;
  localparam int unsigned KCTRL_OFFSET = 4;

  // KCTRL bit indices
  localparam int unsigned KCTRL_READY   = 0;
  localparam int unsigned KCTRL_OVERRUN = 2;
  localparam int unsigned KCTRL_IE      = 8;

  // Pack the status/control fields into a KCTRL read word
  function automatic logic [BUS_BITS-1:0] kctrlWord(input logic ie,
                                                    input logic overrun,
                                                    input logic ready);
    logic [BUS_BITS-1:0] word;
    word                = '0;
    word[KCTRL_IE]      = ie;
    word[KCTRL_OVERRUN] = overrun;
    word[KCTRL_READY]   = ready;
    return word;
  endfunction

endpackage

// File: rtl/key_device_if.sv
// key_device_if: processor data bus shared by the memory-mapped peripherals.
//   we         - 1 = write, 0 = read (driven by the bus master)
//   memAddr    - byte address (driven by the bus master)
//   dataBusIn  - write data (driven by the bus master)
//   dataBusOut - read data (driven by the addressed peripheral, 0 otherwise)
interface key_device_if #(
  parameter int unsigned BITS = 32
);
  logic            we;
  logic [BITS-1:0] memAddr;
  logic [BITS-1:0] dataBusIn;
  logic [BITS-1:0] dataBusOut;

  modport master (output we, output memAddr, output dataBusIn, input dataBusOut);
  modport slave  (input we, input memAddr, input dataBusIn, output dataBusOut);
endinterface

// File: rtl/key_debounce.sv
// key_debounce: one push-button input path.
//   A 2-flop synchronizer turns the asynchronous active-low pin into a
//   synchronous "pressed" level; a counter accepts a new level only after it
//   has differed from the accepted one for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk, reset (synchronous, active-low)
//   keyRaw   - raw pin, 0 = pressed
//   stable   - debounced state, 1 = pressed (registered)
//   update_c - high in the cycle where stable takes a new value (combinational)
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
)(
  input  logic clk,
  input  logic reset,
  input  logic keyRaw,
  output logic stable,
  output logic update_c
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             sampled_c;
  logic [CNT_W-1:0] count;

  // Synchronizer holds raw pin polarity, so reset loads "released"
  assign sampled_c = ~sync2;
  assign update_c  = (sampled_c != stable) && (count == LAST);

  // Synchronizer, debounce counter and accepted state
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      stable <= 1'b0;
      count  <= '0;
    end else begin
      sync1 <= keyRaw;
      sync2 <= sync1;
      if ((sampled_c == stable) || update_c) begin
        count <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
      if (update_c) begin
        stable <= sampled_c;
      end
    end
  end

endmodule

// File: rtl/key_device.sv
// key_device: memory-mapped push-button input peripheral.
//   KDATA at BASE     : debounced key state, 1 = pressed (read-only)
//   KCTRL at BASE + 4 : bit0 ready (RO), bit2 overrun (write 0 clears), bit8 ie
//   Reading KDATA clears ready; a key change sets ready, and sets overrun when
//   ready was still set and not being read in the same cycle.
// Ports:
//   clk, reset (synchronous, active-low)
//   bus  - key_device_if slave: we, memAddr, dataBusIn, dataBusOut
//   key  - raw active-low push-button pins, asynchronous to clk
//   irq  - registered ready & ie, present only when KEY_IRQ_EN is defined
// Build option: define KEY_IRQ_EN to add the irq output.
module key_device
  import key_device_pkg::*;
#(
  parameter int unsigned     KEY_WIDTH       = 4,
  parameter int unsigned     BITS            = 32,
  parameter logic [BITS-1:0] BASE            = BITS'(KEY_BASE),
  parameter int unsigned     DEBOUNCE_CYCLES = 500000
)(
  input  logic                 clk,
  input  logic                 reset,
  key_device_if.slave          bus,
  input  logic [KEY_WIDTH-1:0] key
`ifdef KEY_IRQ_EN
  ,
  output logic                 irq
`endif
);

  localparam logic [BITS-1:0] KDATA_ADDR = BASE + BITS'(KDATA_OFFSET);
  localparam logic [BITS-1:0] KCTRL_ADDR = BASE + BITS'(KCTRL_OFFSET);

  logic [KEY_WIDTH-1:0] kdata;
  logic [KEY_WIDTH-1:0] keyUpdate_c;
  logic                 change_c;
  logic                 kdataRead_c;
  logic                 kctrlWrite_c;
  logic                 ready;
  logic                 overrun;
  logic                 ie;
  logic                 unusedBusBits;

  // One synchronizer + debouncer per key
  for (genvar i = 0; i < KEY_WIDTH; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .reset   (reset),
      .keyRaw  (key[i]),
      .stable  (kdata[i]),
      .update_c(keyUpdate_c[i])
    );
  end

  // Several keys accepted together still count as a single change
  assign change_c     = |keyUpdate_c;
  assign kdataRead_c  = !bus.we && (bus.memAddr == KDATA_ADDR);
  assign kctrlWrite_c =  bus.we && (bus.memAddr == KCTRL_ADDR);
  assign unusedBusBits = ^bus.dataBusIn;

  // Status/control register; a change sets ready even during a KDATA read
  always_ff @(posedge clk) begin
    if (!reset) begin
      ready   <= 1'b0;
      overrun <= 1'b0;
      ie      <= 1'b0;
    end else begin
      if (change_c && ready && !kdataRead_c) begin
        overrun <= 1'b1;
      end else if (kctrlWrite_c && !bus.dataBusIn[KCTRL_OVERRUN]) begin
        overrun <= 1'b0;
      end
      if (change_c) begin
        ready <= 1'b1;
      end else if (kdataRead_c) begin
        ready <= 1'b0;
      end
      if (kctrlWrite_c) begin
        ie <= bus.dataBusIn[KCTRL_IE];
      end
    end
  end

`ifdef KEY_IRQ_EN
  // Interrupt request lags the status bits by one cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      irq <= 1'b0;
    end else begin
      irq <= ready & ie;
    end
  end
`endif

  // Read decode; the bus sees 0 unless this device is addressed by a read
  always_comb begin
    bus.dataBusOut = '0;
    if (!bus.we) begin
      if (bus.memAddr == KDATA_ADDR) begin
        bus.dataBusOut = BITS'(kdata);
      end else if (bus.memAddr == KCTRL_ADDR) begin
        bus.dataBusOut = BITS'(kctrlWord(ie, overrun, ready));
      end
    end
  end

endmodule

// File: tb/tb_key_device.sv
// tb_key_device: self-checking bench for key_device (DEBOUNCE_CYCLES = 4).
//   The reference model accepts a key level once the synchronized samples of
//   the last DEBOUNCE_CYCLES cycles all agree on a value different from the
//   accepted one. Define KEY_IRQ_EN to also check the irq output.
module tb_key_device;

  localparam int unsigned D     = 4;
  localparam logic [31:0] BASE  = 32'hF000_0010;
  localparam logic [31:0] KCTRL = 32'hF000_0014;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key;
`ifdef KEY_IRQ_EN
  logic       irq;
`endif

  int checks   = 0;
  int failures = 0;

  key_device_if #(.BITS(32)) bus();

  key_device #(
    .KEY_WIDTH      (4),
    .BITS           (32),
    .BASE           (BASE),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk  (clk),
    .reset(rst),
    .bus  (bus),
    .key  (key)
`ifdef KEY_IRQ_EN
    ,
    .irq  (irq)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [3:0] rawQ [$];
  logic [3:0] sHist[$];
  logic [3:0] mKdata;
  logic       mReady;
  logic       mOverrun;
  logic       mIe;
`ifdef KEY_IRQ_EN
  logic       mIrq;
`endif
  logic [31:0] addrs[4];

  // Advance the model by one clock edge using the inputs applied right now
  task automatic modelEdge();
    logic [3:0] sNow;
    logic [3:0] newK;
    logic       chg;
    logic       rd;
    logic       wr;
    logic       agree;
    if (!rst) begin
      rawQ = '{4'hF, 4'hF};
      sHist.delete();
      mKdata   = 4'h0;
      mReady   = 1'b0;
      mOverrun = 1'b0;
      mIe      = 1'b0;
`ifdef KEY_IRQ_EN
      mIrq     = 1'b0;
`endif
      return;
    end
    sNow = ~rawQ.pop_front();
    rawQ.push_back(key);
    sHist.push_back(sNow);
    if (sHist.size() > D) void'(sHist.pop_front());
    newK = mKdata;
    if (sHist.size() == D) begin
      for (int i = 0; i < 4; i++) begin
        agree = 1'b1;
        for (int j = 0; j < int'(D); j++) if (sHist[j][i] != sNow[i]) agree = 1'b0;
        if (agree && sNow[i] != mKdata[i]) newK[i] = sNow[i];
      end
    end
    chg = (newK != mKdata);
    rd  = !bus.we && (bus.memAddr == BASE);
    wr  =  bus.we && (bus.memAddr == KCTRL);
`ifdef KEY_IRQ_EN
    mIrq = mReady & mIe;
`endif
    if (chg && mReady && !rd) mOverrun = 1'b1;
    else if (wr && !bus.dataBusIn[2]) mOverrun = 1'b0;
    if (chg) mReady = 1'b1;
    else if (rd) mReady = 1'b0;
    if (wr) mIe = bus.dataBusIn[8];
    mKdata = newK;
  endtask

  // Expected read data for the bus inputs currently applied
  function automatic logic [31:0] expRead();
    if (bus.we) return 32'h0;
    if (bus.memAddr == BASE) return {28'h0, mKdata};
    if (bus.memAddr == KCTRL) return {23'h0, mIe, 5'h0, mOverrun, 1'b0, mReady};
    return 32'h0;
  endfunction

  task automatic step();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b0;
    key = 4'hF;
    bus.we = 1'b0;
    bus.memAddr = KCTRL;
    bus.dataBusIn = 32'h0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    key = 4'hF;
    bus.we = 1'b0;
    bus.dataBusIn = 32'h0;
    for (int c = 0; c < 10; c++) begin
      bus.memAddr = c[0] ? KCTRL : BASE;
      step();
      checks++;
      if (bus.dataBusOut !== 32'h0) begin
        failures++;
        $display("FAIL reset_read cycle %0d: got %h expected 00000000", c, bus.dataBusOut);
      end
`ifdef KEY_IRQ_EN
      checks++;
      if (irq !== 1'b0) begin
        failures++;
        $display("FAIL reset_irq cycle %0d: got %b expected 0", c, irq);
      end
`endif
    end
  endtask

  task automatic test_press();
    rst = 1'b1;
    bus.memAddr = KCTRL;
    step();
    step();
    key = 4'hE;
    for (int c = 1; c <= 6; c++) begin
      step();
      checks++;
      if (bus.dataBusOut !== ((c == 6) ? 32'h1 : 32'h0)) begin
        failures++;
        $display("FAIL press_latency cycle %0d: got %h expected %h", c, bus.dataBusOut,
                 (c == 6) ? 32'h1 : 32'h0);
      end
    end
    bus.memAddr = BASE;
    #1;
    checks++;
    if (bus.dataBusOut !== 32'h1) begin
      failures++;
      $display("FAIL press_kdata: got %h expected 00000001", bus.dataBusOut);
    end
    step();
    bus.memAddr = KCTRL;
    #1;
    checks++;
    if (bus.dataBusOut !== 32'h0) begin
      failures++;
      $display("FAIL press_ready_clear: got %h expected 00000000", bus.dataBusOut);
    end
  endtask

  task automatic test_glitch();
    key = 4'hC;
    for (int c = 0; c < 3; c++) step();
    key = 4'hE;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (bus.dataBusOut !== 32'h0) begin
        failures++;
        $display("FAIL glitch_ready cycle %0d: got %h expected 00000000", c, bus.dataBusOut);
      end
    end
    bus.memAddr = BASE;
    #1;
    checks++;
    if (bus.dataBusOut !== 32'h1) begin
      failures++;
      $display("FAIL glitch_kdata: got %h expected 00000001", bus.dataBusOut);
    end
    step();
  endtask

  task automatic test_overrun();
    doReset();
    key = 4'hE;
    for (int c = 0; c < 8; c++) step();
    checks++;
    if (bus.dataBusOut !== 32'h1) begin
      failures++;
      $display("FAIL overrun_first: got %h expected 00000001", bus.dataBusOut);
    end
    key = 4'hA;
    for (int c = 0; c < 8; c++) step();
    checks++;
    if (bus.dataBusOut !== 32'h5) begin
      failures++;
      $display("FAIL overrun_set: got %h expected 00000005", bus.dataBusOut);
    end
    bus.we = 1'b1;
    bus.memAddr = BASE;
    bus.dataBusIn = 32'hFFFF_FFFF;
    step();
    bus.we = 1'b0;
    bus.memAddr = KCTRL;
    #1;
    checks++;
    if (bus.dataBusOut !== 32'h5) begin
      failures++;
      $display("FAIL kdata_write_ignored: got %h expected 00000005", bus.dataBusOut);
    end
    bus.we = 1'b1;
    bus.dataBusIn = 32'h0;
    step();
    bus.we = 1'b0;
    #1;
    checks++;
    if (bus.dataBusOut !== 32'h1) begin
      failures++;
      $display("FAIL overrun_clear: got %h expected 00000001", bus.dataBusOut);
    end
    bus.memAddr = BASE;
    #1;
    checks++;
    if (bus.dataBusOut !== 32'h5) begin
      failures++;
      $display("FAIL overrun_kdata: got %h expected 00000005", bus.dataBusOut);
    end
    step();
  endtask

  task automatic test_read_align();
    doReset();
    key = 4'hE;
    for (int c = 0; c < 8; c++) step();
    key = 4'hC;
    for (int c = 1; c <= 5; c++) step();
    bus.memAddr = BASE;
    step();
    bus.memAddr = KCTRL;
    #1;
    checks++;
    if (bus.dataBusOut !== 32'h1) begin
      failures++;
      $display("FAIL read_align_status: got %h expected 00000001", bus.dataBusOut);
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    key = 4'hE;
    bus.memAddr = BASE;
    step();
    bus.memAddr = KCTRL;
    key = 4'hB;
    step();
    step();
    step();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      checks++;
      if (bus.dataBusOut !== ((c == 6) ? 32'h1 : 32'h0)) begin
        failures++;
        $display("FAIL reset_mid cycle %0d: got %h expected %h", c, bus.dataBusOut,
                 (c == 6) ? 32'h1 : 32'h0);
      end
    end
    bus.memAddr = BASE;
    #1;
    checks++;
    if (bus.dataBusOut !== 32'h4) begin
      failures++;
      $display("FAIL reset_mid_kdata: got %h expected 00000004", bus.dataBusOut);
    end
    step();
  endtask

  task automatic test_ie_irq();
    doReset();
    bus.we = 1'b1;
    bus.dataBusIn = 32'h100;
    step();
    bus.we = 1'b0;
    #1;
    checks++;
    if (bus.dataBusOut !== 32'h100) begin
      failures++;
      $display("FAIL ie_readback: got %h expected 00000100", bus.dataBusOut);
    end
    key = 4'h7;
    for (int c = 1; c <= 8; c++) begin
      step();
      checks++;
      if (bus.dataBusOut !== ((c >= 6) ? 32'h101 : 32'h100)) begin
        failures++;
        $display("FAIL ie_ready cycle %0d: got %h expected %h", c, bus.dataBusOut,
                 (c >= 6) ? 32'h101 : 32'h100);
      end
`ifdef KEY_IRQ_EN
      checks++;
      if (irq !== (c >= 7)) begin
        failures++;
        $display("FAIL irq_rise cycle %0d: got %b expected %b", c, irq, c >= 7);
      end
`endif
    end
    bus.memAddr = BASE;
    step();
    bus.memAddr = KCTRL;
    #1;
    checks++;
    if (bus.dataBusOut !== 32'h100) begin
      failures++;
      $display("FAIL ie_read_clear: got %h expected 00000100", bus.dataBusOut);
    end
`ifdef KEY_IRQ_EN
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_lag: got %b expected 1", irq);
    end
    step();
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_fall: got %b expected 0", irq);
    end
`endif
    bus.we = 1'b1;
    bus.dataBusIn = 32'h4;
    step();
    bus.we = 1'b0;
    #1;
    checks++;
    if (bus.dataBusOut !== 32'h0) begin
      failures++;
      $display("FAIL ie_clear: got %h expected 00000000", bus.dataBusOut);
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    doReset();
    for (int c = 0; c < 1500; c++) begin
      if (hold == 0) begin
        key  = 4'($urandom);
        hold = int'($urandom_range(1, 8));
      end
      hold--;
      rst = ($urandom_range(0, 299) != 0);
      bus.memAddr   = addrs[$urandom_range(0, 3)];
      bus.we        = ($urandom_range(0, 3) == 0);
      bus.dataBusIn = $urandom;
      step();
      checks++;
      if (bus.dataBusOut !== expRead()) begin
        failures++;
        $display("FAIL random_read cycle %0d addr %h we %b: got %h expected %h",
                 c, bus.memAddr, bus.we, bus.dataBusOut, expRead());
      end
`ifdef KEY_IRQ_EN
      checks++;
      if (irq !== mIrq) begin
        failures++;
        $display("FAIL random_irq cycle %0d: got %b expected %b", c, irq, mIrq);
      end
`endif
    end
  endtask

  initial begin
    addrs[0] = BASE;
    addrs[1] = KCTRL;
    addrs[2] = BASE + 32'h8;
    addrs[3] = 32'hF000_0000;
    test_reset();
    test_press();
    test_glitch();
    test_overrun();
    test_read_align();
    test_reset_mid();
    test_ie_irq();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
